// File: rtl/cr_rst_req_ctrl.sv
// CPU reset-request sequencer (always-on debug domain): gathers wdt/had/sw requests,
// drives a minimum-width active-low request to the reset top and tracks the handshake.
module cr_rst_req_ctrl #(
    parameter int HOLD_CYC = 16,
    parameter int ACK_TO   = 64,
    parameter int COOL_CYC = 8
) (
    input  logic       forever_cpuclk,
    input  logic       hadrst_b,
    input  logic       wdt_rst_req,
    input  logic       had_rst_req,
    input  logic       sw_rst_req,
    input  logic       rst_cause_clr,
    input  logic       cpurst_b,
    output logic       rst_req_cpu_b,
    output logic       rst_req_busy,
    output logic [2:0] rst_cause,
    output logic       rst_err,
    output logic       had_rst_ack
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
    localparam logic [7:0] ACK_LAST  = 8'(ACK_TO - 1);
    localparam logic [7:0] COOL_LAST = 8'(COOL_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ASSERT   = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_COOL     = 3'd4
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] cnt_r, cnt_s;
    logic [2:0] pend_r, pend_s;
    logic [2:0] req_s, pend_req_s, capture_s;
    logic [2:0] cause_r, cause_s;
    logic       had_seq_r, had_seq_s;
    logic       err_r, err_s, err_set_s;
    logic       req_cpu_b_r, req_cpu_b_s;
    logic       busy_r, busy_s;
    logic       ack_r, ack_s;
    logic [1:0] sync_r;
    logic       cpurst_s;

    assign req_s      = {wdt_rst_req, had_rst_req, sw_rst_req};
    assign pend_req_s = pend_r | req_s;
    assign cpurst_s   = sync_r[1];

    assign rst_req_cpu_b = req_cpu_b_r;
    assign rst_req_busy  = busy_r;
    assign rst_cause     = cause_r;
    assign rst_err       = err_r;
    assign had_rst_ack   = ack_r;

    // Two-flop synchroniser for the asynchronous CPU reset coming back from the reset top
    always_ff @(posedge forever_cpuclk or negedge hadrst_b) begin
        if (!hadrst_b) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], cpurst_b};
        end
    end

    // Next-state, counter, pending/cause bookkeeping and next registered outputs
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pend_s    = pend_req_s;
        had_seq_s = had_seq_r;
        capture_s = 3'b000;
        err_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = 8'd0;
                if (pend_req_s != 3'b000) begin
                    state_s   = ST_ASSERT;
                    pend_s    = 3'b000;
                    capture_s = pend_req_s;
                    had_seq_s = pend_req_s[1];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (cnt_r == HOLD_LAST) begin
                    state_s = ST_WAIT_ACK;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_WAIT_ACK: begin
                if (!cpurst_s) begin
                    state_s = ST_RELEASE;
                    cnt_s   = 8'd0;
                end else if (cnt_r == ACK_LAST) begin
                    state_s   = ST_RELEASE;
                    cnt_s     = 8'd0;
                    err_set_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            // No timeout here: a held pad reset keeps the sequence parked
            ST_RELEASE: begin
                if (cpurst_s) begin
                    state_s = ST_COOL;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = ST_RELEASE;
                end
            end
            ST_COOL: begin
                if (cnt_r == COOL_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_s     = 8'd0;
                had_seq_s = 1'b0;
            end
        endcase

        // A clear in the same cycle as a capture/error keeps only the newly written bits
        cause_s     = rst_cause_clr ? capture_s : (cause_r | capture_s);
        err_s       = rst_cause_clr ? err_set_s : (err_r | err_set_s);
        req_cpu_b_s = !((state_s == ST_ASSERT) || (state_s == ST_WAIT_ACK));
        busy_s      = (state_s != ST_IDLE);
        ack_s       = (state_s == ST_COOL) && (state_r != ST_COOL) && had_seq_r;
    end

    // State and registered-output flops
    always_ff @(posedge forever_cpuclk or negedge hadrst_b) begin
        if (!hadrst_b) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            pend_r      <= 3'b000;
            had_seq_r   <= 1'b0;
            cause_r     <= 3'b000;
            err_r       <= 1'b0;
            req_cpu_b_r <= 1'b1;
            busy_r      <= 1'b0;
            ack_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            pend_r      <= pend_s;
            had_seq_r   <= had_seq_s;
            cause_r     <= cause_s;
            err_r       <= err_s;
            req_cpu_b_r <= req_cpu_b_s;
            busy_r      <= busy_s;
            ack_r       <= ack_s;
        end
    end

endmodule

// File: tb/tb_cr_rst_req_ctrl.sv
// Scoreboard bench for cr_rst_req_ctrl: expected sequence records are queued at stimulus
// time and a monitor compares each one when the DUT finishes a sequence (busy falls).
module tb_cr_rst_req_ctrl;

    logic       clk = 1'b0;
    logic       hadrst_b, wdt, had, sw, clr, cpurst_b;
    logic       req_b, busy, err, ack;
    logic [2:0] cause;

    int checks   = 0;
    int failures = 0;

    int ack_delay = 5;
    int ack_hold  = 10;

    typedef struct {
        int         low;
        int         busy;
        logic [2:0] cause;
        logic       err;
        int         acks;
        int         ack_idx;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_exp;

    int m_busy, m_low, m_acks, m_ack_idx, seq_no;
    logic prev_busy;
    int rt_phase, rt_lowcnt, rt_held;

    always #5 clk = ~clk;

    cr_rst_req_ctrl #(.HOLD_CYC(16), .ACK_TO(64), .COOL_CYC(8)) dut (
        .forever_cpuclk(clk),
        .hadrst_b      (hadrst_b),
        .wdt_rst_req   (wdt),
        .had_rst_req   (had),
        .sw_rst_req    (sw),
        .rst_cause_clr (clr),
        .cpurst_b      (cpurst_b),
        .rst_req_cpu_b (req_b),
        .rst_req_busy  (busy),
        .rst_cause     (cause),
        .rst_err       (err),
        .had_rst_ack   (ack)
    );

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_seq(input int low, input int bsy, input logic [2:0] c,
                              input logic e, input int acks, input int idx);
        exp_t x;
        x.low = low; x.busy = bsy; x.cause = c; x.err = e; x.acks = acks; x.ack_idx = idx;
        sb_q.push_back(x);
    endtask

    // mask = {clr, wdt, had, sw}; returns on the negedge of the cycle after the pulse
    task automatic pulse(input logic [3:0] m);
        @(negedge clk);
        {clr, wdt, had, sw} = m;
        @(negedge clk);
        {clr, wdt, had, sw} = 4'b0000;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_int(name, int'(busy), 0);
    endtask

    // Reset-top model: asserts cpurst_b ack_delay cycles into the low request,
    // releases once the request is high and ack_hold cycles have elapsed
    initial begin : reset_top
        rt_phase = 0; rt_lowcnt = 0; rt_held = 0;
        forever begin
            @(negedge clk);
            if (!hadrst_b) begin
                rt_phase = 0; rt_lowcnt = 0; cpurst_b = 1'b1;
            end else if (rt_phase == 0) begin
                if (!req_b && ack_delay != 0) begin
                    rt_lowcnt++;
                    if (rt_lowcnt >= ack_delay) begin
                        cpurst_b = 1'b0; rt_phase = 1; rt_held = 0;
                    end
                end else begin
                    rt_lowcnt = 0;
                end
            end else begin
                rt_held++;
                if (rt_held >= ack_hold && req_b) begin
                    cpurst_b = 1'b1; rt_phase = 0; rt_lowcnt = 0;
                end
            end
        end
    end

    initial begin : monitor
        m_busy = 0; m_low = 0; m_acks = 0; m_ack_idx = -1; prev_busy = 1'b0; seq_no = 0;
        forever begin
            @(negedge clk);
            if (!hadrst_b) begin
                m_busy = 0; m_low = 0; m_acks = 0; m_ack_idx = -1; prev_busy = 1'b0;
            end else begin
                if (busy) begin
                    if (!req_b) m_low++;
                    if (ack) begin
                        m_acks++;
                        m_ack_idx = m_busy;
                    end
                    m_busy++;
                end else if (prev_busy) begin
                    seq_no++;
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_sequence #%0d actual=present expected=none", seq_no);
                    end else begin
                        m_exp = sb_q.pop_front();
                        check_int($sformatf("seq%0d_low_cycles", seq_no), m_low, m_exp.low);
                        check_int($sformatf("seq%0d_busy_cycles", seq_no), m_busy, m_exp.busy);
                        check_int($sformatf("seq%0d_cause", seq_no), int'(cause), int'(m_exp.cause));
                        check_int($sformatf("seq%0d_err", seq_no), int'(err), int'(m_exp.err));
                        check_int($sformatf("seq%0d_ack_pulses", seq_no), m_acks, m_exp.acks);
                        if (m_exp.acks > 0)
                            check_int($sformatf("seq%0d_ack_cycle", seq_no), m_ack_idx, m_exp.ack_idx);
                    end
                    m_busy = 0; m_low = 0; m_acks = 0; m_ack_idx = -1;
                end
                prev_busy = busy;
            end
        end
    end

    initial begin : stimulus
        hadrst_b = 1'b0;
        {clr, wdt, had, sw} = 4'b0000;
        cpurst_b = 1'b1;
        repeat (3) @(negedge clk);
        check_int("reset_req_b", int'(req_b), 1);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_cause", int'(cause), 0);
        check_int("reset_err", int'(err), 0);
        check_int("reset_ack", int'(ack), 0);
        hadrst_b = 1'b1;
        repeat (2) @(negedge clk);

        // Single sw request: 16 hold + 1 wait-ack cycle low, 3 release, 8 cool
        expect_seq(17, 28, 3'b001, 1'b0, 0, -1);
        pulse(4'b0001);
        check_int("sw_start_req_b", int'(req_b), 0);
        check_int("sw_start_busy", int'(busy), 1);
        wait_idle("sw_idle", 200);

        // Clear coinciding with a wdt capture over prior cause 001
        expect_seq(17, 28, 3'b100, 1'b0, 0, -1);
        pulse(4'b1100);
        check_int("clr_capture_cause", int'(cause), 4);
        wait_idle("clr_capture_idle", 200);
        pulse(4'b1000);
        check_int("clr_cause", int'(cause), 0);

        // wdt + had together: one sequence, ack on first cool cycle
        expect_seq(17, 28, 3'b110, 1'b0, 1, 20);
        pulse(4'b0110);
        wait_idle("dual_idle", 200);
        repeat (5) @(negedge clk);
        check_int("dual_single_seq", int'(busy), 0);
        pulse(4'b1000);

        // Ack timeout on a had sequence: 16+64 low, 1 release, 8 cool
        ack_delay = 0;
        expect_seq(80, 89, 3'b010, 1'b1, 1, 81);
        pulse(4'b0010);
        wait_idle("timeout_idle", 300);
        check_int("timeout_req_b", int'(req_b), 1);
        check_int("timeout_err", int'(err), 1);
        pulse(4'b1000);
        check_int("timeout_err_cleared", int'(err), 0);
        ack_delay = 5;

        // sw during ASSERT of a had sequence: back-to-back second sequence
        expect_seq(17, 28, 3'b010, 1'b0, 1, 20);
        expect_seq(17, 28, 3'b011, 1'b0, 0, -1);
        pulse(4'b0010);
        repeat (3) @(negedge clk);
        pulse(4'b0001);
        wait_idle("b2b_first_idle", 200);
        @(negedge clk);
        check_int("b2b_restart_busy", int'(busy), 1);
        wait_idle("b2b_second_idle", 200);
        pulse(4'b1000);

        // Debug reset during WAIT_ACK, then a full fresh sequence
        ack_delay = 0;
        pulse(4'b0001);
        repeat (20) @(negedge clk);
        hadrst_b = 1'b0;
        #1;
        check_int("hadrst_req_b", int'(req_b), 1);
        check_int("hadrst_busy", int'(busy), 0);
        check_int("hadrst_cause", int'(cause), 0);
        check_int("hadrst_err", int'(err), 0);
        check_int("hadrst_ack", int'(ack), 0);
        repeat (2) @(negedge clk);
        hadrst_b = 1'b1;
        ack_delay = 5;
        repeat (2) @(negedge clk);
        expect_seq(17, 28, 3'b001, 1'b0, 0, -1);
        pulse(4'b0001);
        wait_idle("post_hadrst_idle", 200);

        repeat (3) @(negedge clk);
        check_int("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cr_rst_req_ctrl.md
# cr_rst_req_ctrl

Reset-request sequencer for the CPU reset path, in the always-on debug reset domain. It collects CPU reset requests from the watchdog, the debug module and software. It drives one active-low, minimum-width request toward the reset top (combined there with the pad CPU reset), then waits for the CPU reset to assert and release. It records the cause, acknowledges the debug requester and blanks new requests for a cool-down period.

## Interface
Parameters:
- HOLD_CYC, 16: cycles rst_req_cpu_b is held low before acknowledge is checked (2..255)
- ACK_TO, 64: cycles WAIT_ACK waits for CPU reset assertion before timeout (4..255)
- COOL_CYC, 8: post-release blanking cycles (1..255)

Ports:
- forever_cpuclk  in  1  ungated CPU clock, all state on rising edge
- hadrst_b  in  1  asynchronous active-low reset (debug domain; unaffected by the CPU reset this block requests)
- wdt_rst_req  in  1  watchdog reset request, single-cycle pulse
- had_rst_req  in  1  debug reset request, single-cycle pulse
- sw_rst_req  in  1  software reset request, single-cycle pulse
- rst_cause_clr  in  1  clear rst_cause and rst_err, single-cycle pulse
- cpurst_b  in  1  CPU reset from reset top; asynchronous to this logic, 2-flop synchronised internally (cpurst_s)
- rst_req_cpu_b  out  1  registered active-low reset request to reset top
- rst_req_busy  out  1  high in every state except IDLE
- rst_cause  out  3  sticky cause: [0] sw, [1] had, [2] wdt
- rst_err  out  1  sticky: WAIT_ACK timed out
- had_rst_ack  out  1  single-cycle pulse, debug-originated sequence completed

## Operation
- Reset values: rst_req_cpu_b=1, rst_req_busy=0, rst_cause=0, rst_err=0, had_rst_ack=0, state=IDLE, pend=0, counter=0, sync flops=1.
- pend[2:0]: request pulses are OR-ed into pend in every state. pend clears on IDLE->ASSERT.
- States:
  - IDLE: if pend|req is non-zero, go to ASSERT. rst_cause takes pend|req, OR-ed into its existing value. Counter loads 0.
  - ASSERT: rst_req_cpu_b=0. Counter increments. At counter==HOLD_CYC-1, go to WAIT_ACK with counter=0.
  - WAIT_ACK: rst_req_cpu_b=0.
    - cpurst_s==0: go to RELEASE.
    - counter==ACK_TO-1 and cpurst_s still 1: set rst_err, go to RELEASE.
  - RELEASE: rst_req_cpu_b=1. Wait for cpurst_s==1. If the sequence timed out, cpurst_s is already 1 and the state exits after one cycle. Then go to COOL with counter=0.
  - COOL: rst_req_cpu_b=1. On the first COOL cycle, had_rst_ack=1 if the had bit was captured at the start of this sequence (a sequence-local flag, not rst_cause). At counter==COOL_CYC-1, go to IDLE.
- Requests arriving outside IDLE are only latched in pend. A new sequence starts from IDLE on the cycle after COOL ends. Requests are never dropped.
- Simultaneous requests produce one sequence, and every simultaneous source sets its cause bit.
- rst_cause_clr clears rst_cause and rst_err. If a capture or error-set happens in the same cycle, the new bits are written and all other bits clear.
- RELEASE has no timeout. If the reset top holds cpurst_b low indefinitely (pad reset held), the block waits.
- hadrst_b asserted mid-sequence: all state returns to reset values immediately, including rst_req_cpu_b=1 asynchronously.

## Timing
- Request pulse in cycle N: state=ASSERT and rst_req_cpu_b=0 from cycle N+1.
- rst_req_cpu_b stays low for exactly HOLD_CYC cycles plus the WAIT_ACK cycles.
- Acknowledge latency is 2 synchroniser cycles plus 1 state cycle after cpurst_b falls.
- RELEASE to COOL: 3 cycles after cpurst_b rises.
- Minimum spacing between two rst_req_cpu_b low windows is COOL_CYC+2 cycles after release completes.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- Single sw_rst_req, reset top asserts cpurst_b 5 cycles after request goes low and holds it 10 cycles (defaults) -> rst_req_cpu_b low for 16 cycles plus ack cycles; rst_cause=3'b001; had_rst_ack never pulses; busy returns to 0 after 8 COOL cycles.
- wdt_rst_req and had_rst_req in the same cycle -> exactly one sequence; rst_cause=3'b110; one had_rst_ack pulse on the first COOL cycle.
- cpurst_b never falls -> rst_err=1 after 16+64 low cycles; rst_req_cpu_b=1; had_rst_ack pulses if the had bit was captured; sequence ends in IDLE.
- sw_rst_req during ASSERT of a had sequence -> second sequence starts the cycle after COOL ends; rst_cause=3'b011.
- hadrst_b pulsed low during WAIT_ACK -> rst_req_cpu_b=1 immediately; all outputs at reset values; a new request after release runs a full sequence.
- rst_cause_clr in the same cycle as an IDLE->ASSERT capture of wdt, with prior cause 3'b001 -> rst_cause=3'b100.
